// File: rtl/mem.sv
// Reciprocal letter-substitution stage: one ASCII character per clock is mapped
// through one of four fixed involutive pairing blocks chosen by `setting`.
module mem (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:1] in,
    input  logic [1:0] setting,
    input  logic       in_valid,
    output logic [8:1] out,
    output logic       out_valid
);

    logic       is_letter;
    logic [7:0] offset;
    logic [4:0] idx;
    logic [4:0] map0, map1, map2, map3, map_sel;
    logic [8:1] mapped;

    // Each block lists its pairs once in both directions; indices 26..31 never
    // occur for a letter and simply fall through to the default.
    function automatic logic [4:0] blk0(input logic [4:0] i);
        logic [4:0] m;
        m = i;
        case (i)
            5'd0:  m = 5'd14;  5'd14: m = 5'd0;
            5'd1:  m = 5'd2;   5'd2:  m = 5'd1;
            5'd3:  m = 5'd4;   5'd4:  m = 5'd3;
            5'd5:  m = 5'd6;   5'd6:  m = 5'd5;
            5'd7:  m = 5'd8;   5'd8:  m = 5'd7;
            5'd9:  m = 5'd10;  5'd10: m = 5'd9;
            5'd11: m = 5'd24;  5'd24: m = 5'd11;
            5'd12: m = 5'd13;  5'd13: m = 5'd12;
            5'd15: m = 5'd16;  5'd16: m = 5'd15;
            5'd17: m = 5'd18;  5'd18: m = 5'd17;
            5'd19: m = 5'd20;  5'd20: m = 5'd19;
            5'd21: m = 5'd22;  5'd22: m = 5'd21;
            5'd23: m = 5'd25;  5'd25: m = 5'd23;
            default: m = i;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] blk1(input logic [4:0] i);
        logic [4:0] m;
        m = i;
        case (i)
            5'd0:  m = 5'd1;   5'd1:  m = 5'd0;
            5'd2:  m = 5'd3;   5'd3:  m = 5'd2;
            5'd4:  m = 5'd18;  5'd18: m = 5'd4;
            5'd5:  m = 5'd6;   5'd6:  m = 5'd5;
            5'd7:  m = 5'd8;   5'd8:  m = 5'd7;
            5'd9:  m = 5'd11;  5'd11: m = 5'd9;
            5'd10: m = 5'd22;  5'd22: m = 5'd10;
            5'd12: m = 5'd13;  5'd13: m = 5'd12;
            5'd14: m = 5'd15;  5'd15: m = 5'd14;
            5'd16: m = 5'd17;  5'd17: m = 5'd16;
            5'd19: m = 5'd20;  5'd20: m = 5'd19;
            5'd21: m = 5'd23;  5'd23: m = 5'd21;
            5'd24: m = 5'd25;  5'd25: m = 5'd24;
            default: m = i;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] blk2(input logic [4:0] i);
        logic [4:0] m;
        m = i;
        case (i)
            5'd0:  m = 5'd1;   5'd1:  m = 5'd0;
            5'd2:  m = 5'd7;   5'd7:  m = 5'd2;
            5'd3:  m = 5'd11;  5'd11: m = 5'd3;
            5'd4:  m = 5'd5;   5'd5:  m = 5'd4;
            5'd6:  m = 5'd14;  5'd14: m = 5'd6;
            5'd8:  m = 5'd9;   5'd9:  m = 5'd8;
            5'd10: m = 5'd12;  5'd12: m = 5'd10;
            5'd13: m = 5'd15;  5'd15: m = 5'd13;
            5'd16: m = 5'd17;  5'd17: m = 5'd16;
            5'd18: m = 5'd19;  5'd19: m = 5'd18;
            5'd20: m = 5'd21;  5'd21: m = 5'd20;
            5'd22: m = 5'd23;  5'd23: m = 5'd22;
            5'd24: m = 5'd25;  5'd25: m = 5'd24;
            default: m = i;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] blk3(input logic [4:0] i);
        logic [4:0] m;
        m = i;
        case (i)
            5'd0:  m = 5'd1;   5'd1:  m = 5'd0;
            5'd2:  m = 5'd3;   5'd3:  m = 5'd2;
            5'd4:  m = 5'd5;   5'd5:  m = 5'd4;
            5'd6:  m = 5'd8;   5'd8:  m = 5'd6;
            5'd7:  m = 5'd17;  5'd17: m = 5'd7;
            5'd9:  m = 5'd10;  5'd10: m = 5'd9;
            5'd11: m = 5'd16;  5'd16: m = 5'd11;
            5'd12: m = 5'd13;  5'd13: m = 5'd12;
            5'd14: m = 5'd15;  5'd15: m = 5'd14;
            5'd18: m = 5'd19;  5'd19: m = 5'd18;
            5'd20: m = 5'd21;  5'd21: m = 5'd20;
            5'd22: m = 5'd23;  5'd23: m = 5'd22;
            5'd24: m = 5'd25;  5'd25: m = 5'd24;
            default: m = i;
        endcase
        return m;
    endfunction

    always_comb begin
        is_letter = (in >= 8'h41) && (in <= 8'h5A);
        offset    = in - 8'h41;
        idx       = offset[4:0];
        map0      = blk0(idx);
        map1      = blk1(idx);
        map2      = blk2(idx);
        map3      = blk3(idx);
        case (setting)
            2'd0:    map_sel = map0;
            2'd1:    map_sel = map1;
            2'd2:    map_sel = map2;
            default: map_sel = map3;
        endcase
        mapped = is_letter ? (8'h41 + {3'b000, map_sel}) : in;
    end

    // `out` keeps its last result across idle cycles; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out <= mapped;
        end
    end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: pair-list reference model, per-cycle compare,
// directed vectors, exhaustive involution/permutation sweep and random traffic.
module tb_mem;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:1] in = 8'h00;
    logic [1:0] setting = 2'd0;
    logic       in_valid = 1'b0;
    logic [8:1] out;
    logic       out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_out = 8'h00;
    logic       exp_v = 1'b0;

    string pairs [4] = '{"AOBCDEFGHIJKLYMNPQRSTUVWXZ",
                         "ABCDESFGHIJLKWMNOPQRTUVXYZ",
                         "ABCHDLEFGOIJKMNPQRSTUVWXYZ",
                         "ABCDEFGIHRJKLQMNOPSTUVWXYZ"};

    mem dut (
        .clk(clk), .rst_n(rst_n), .in(in), .setting(setting),
        .in_valid(in_valid), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] c, input int s);
        string p;
        p = pairs[s];
        if (c < 8'h41 || c > 8'h5A) return c;
        for (int k = 0; k < 26; k++)
            if (p[k] == c) return p[k ^ 1];
        return 8'h3F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: result of a sampled character appears one edge later.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_out <= 8'h00;
            exp_v   <= 1'b0;
        end else if (in_valid) begin
            exp_out <= model(in, int'(setting));
            exp_v   <= 1'b1;
        end else begin
            exp_v <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        chk("out", {24'b0, out}, {24'b0, exp_out});
    end

    task automatic xfer(input logic [7:0] c, input int s, output logic [7:0] r);
        @(negedge clk);
        in = c; setting = s[1:0]; in_valid = 1'b1;
        @(negedge clk);
        r = out;
    endtask

    initial begin
        string pt, ct, got;
        int sq [10] = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1};
        logic [7:0] r, r2;
        logic [7:0] pass_vals [4] = '{8'h61, 8'h30, 8'h00, 8'hFF};
        logic [25:0] seen;

        #1;
        chk("reset_out", {24'b0, out}, 32'h0);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
        chk("model_H2", {24'b0, model("H", 2)}, {24'b0, 8'h43});
        chk("model_L0", {24'b0, model("L", 0)}, {24'b0, 8'h59});
        chk("model_R3", {24'b0, model("R", 3)}, {24'b0, 8'h48});
        #11 rst_n = 1'b1;

        // Back-to-back encrypt, then decrypt with the same setting sequence.
        pt = "HELLOWORLD";
        ct = "CSYQGKAHDC";
        for (int pass = 0; pass < 2; pass++) begin
            got = pass == 0 ? pt : ct;
            for (int i = 0; i <= 10; i++) begin
                @(negedge clk);
                if (i > 0) begin
                    chk("stream_valid", {31'b0, out_valid}, 32'h1);
                    chk(pass == 0 ? "encrypt" : "decrypt", {24'b0, out},
                        {24'b0, (pass == 0 ? ct[i-1] : pt[i-1])});
                end
                if (i < 10) begin
                    in = got[i]; setting = sq[i][1:0]; in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end

        // Every block is a fixed-point-free involution and a permutation of A-Z.
        for (int s = 0; s < 4; s++) begin
            seen = '0;
            for (int x = 0; x < 26; x++) begin
                xfer(8'h41 + 8'(x), s, r);
                xfer(r, s, r2);
                chk("involution", {24'b0, r2}, 32'(8'h41 + x));
                if (r >= 8'h41 && r <= 8'h5A) seen[r - 8'h41] = 1'b1;
                n_cmp++;
                if (r == 8'h41 + 8'(x)) begin
                    n_bad++;
                    $display("FAIL fixed_point: s=%0d got %h equals input", s, r);
                end
            end
            chk("permutation", {6'b0, seen}, {6'b0, {26{1'b1}}});
        end

        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++) begin
                xfer(pass_vals[k], s, r);
                chk("passthrough", {24'b0, r}, {24'b0, pass_vals[k]});
            end

        // Reset pulled between edges clears at once; in-flight char dropped.
        @(negedge clk);
        in = "Q"; setting = 2'd1; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {24'b0, out}, 32'h0);
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        xfer("L", 0, r);
        chk("after_reset_L0", {24'b0, r}, {24'b0, 8'h59});

        // Valid gating: idle cycle holds out and drops out_valid.
        @(negedge clk);
        in = "H"; setting = 2'd2; in_valid = 1'b0;
        @(negedge clk);
        chk("gate_hold_out", {24'b0, out}, {24'b0, 8'h59});
        chk("gate_valid_low", {31'b0, out_valid}, 32'h0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("gate_then_H2", {24'b0, out}, {24'b0, 8'h43});

        // Random traffic, mostly letters, checked by the per-cycle compare.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            setting  = 2'($urandom_range(0, 3));
            in       = ($urandom_range(0, 4) != 0) ? 8'(8'h41 + $urandom_range(0, 25))
                                                   : 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
